// File: rtl/reorder_buffer.sv
// Circular reorder buffer: hands out tags to rename, records dispatch metadata and CDB results,
// and retires up to PIPE_WIDTH completed entries per cycle in program order.
module reorder_buffer #(
    parameter int unsigned ROB_DEPTH  = 16,
    parameter int unsigned PIPE_WIDTH = 2,
    parameter int unsigned TAG_WIDTH  = $clog2(ROB_DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_flush,
    input  logic [PIPE_WIDTH-1:0]                 i_rob_alloc_req,
    output logic [PIPE_WIDTH-1:0]                 o_rob_alloc_gnt,
    output logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0]  o_rob_alloc_tags,
    input  logic                                  i_rob_alloc_fire,
    input  logic [PIPE_WIDTH-1:0]                 i_rob_disp_we,
    input  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0]  i_rob_disp_tag,
    input  logic [PIPE_WIDTH-1:0][4:0]            i_rob_disp_rd,
    input  logic [PIPE_WIDTH-1:0]                 i_rob_disp_has_rd,
    input  logic [PIPE_WIDTH-1:0][31:0]           i_rob_disp_pc,
    input  logic [PIPE_WIDTH-1:0]                 i_cdb_valid,
    input  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0]  i_cdb_tag,
    input  logic [PIPE_WIDTH-1:0][31:0]           i_cdb_data,
    output logic [PIPE_WIDTH-1:0]                 o_commit_we,
    output logic [PIPE_WIDTH-1:0][4:0]            o_commit_addr,
    output logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0]  o_commit_tag,
    output logic [PIPE_WIDTH-1:0][31:0]           o_commit_data,
    output logic [PIPE_WIDTH-1:0][31:0]           o_commit_pc,
    output logic [TAG_WIDTH:0]                    o_rob_count,
    output logic                                  o_rob_empty
);
    localparam int unsigned CNT_W = TAG_WIDTH + 1;

    logic [TAG_WIDTH-1:0] r_head;
    logic [TAG_WIDTH-1:0] r_tail;
    logic [CNT_W-1:0]     r_count;
    logic [ROB_DEPTH-1:0] r_valid;
    logic [ROB_DEPTH-1:0] r_done;
    logic [ROB_DEPTH-1:0] r_has_rd;
    logic [4:0]           r_rd   [ROB_DEPTH];
    logic [31:0]          r_pc   [ROB_DEPTH];
    logic [31:0]          r_data [ROB_DEPTH];

    logic [CNT_W-1:0]                     w_free;
    logic [CNT_W-1:0]                     w_need;
    logic [CNT_W-1:0]                     w_alloc_n;
    logic [CNT_W-1:0]                     w_commit_n;
    logic [CNT_W-1:0]                     w_count_next;
    logic [PIPE_WIDTH-1:0]                w_alloc;
    logic [PIPE_WIDTH-1:0]                w_commit;
    logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] w_cidx;
    logic                                 w_run;

    // Free space uses registered count only, so a same-cycle commit never frees a slot.
    always_comb begin
        w_free           = CNT_W'(ROB_DEPTH) - r_count;
        w_need           = '0;
        o_rob_alloc_gnt  = '0;
        o_rob_alloc_tags = '0;
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            o_rob_alloc_tags[i] = r_tail + w_need[TAG_WIDTH-1:0];
            if (i_rob_alloc_req[i]) begin
                w_need = w_need + CNT_W'(1);
            end
            o_rob_alloc_gnt[i] = i_rob_alloc_req[i] && (w_free >= w_need) && rst_n && !i_flush;
        end
        if (!rst_n) begin
            o_rob_alloc_tags = '0;
        end
    end

    always_comb begin
        w_alloc   = '0;
        w_alloc_n = '0;
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            w_alloc[i] = i_rob_alloc_fire && i_rob_alloc_req[i] && o_rob_alloc_gnt[i];
            if (w_alloc[i]) begin
                w_alloc_n = w_alloc_n + CNT_W'(1);
            end
        end
    end

    // Lane c retires only if every older lane retires this cycle.
    always_comb begin
        w_run         = rst_n && !i_flush;
        w_commit      = '0;
        w_commit_n    = '0;
        w_cidx        = '0;
        o_commit_we   = '0;
        o_commit_addr = '0;
        o_commit_tag  = '0;
        o_commit_data = '0;
        o_commit_pc   = '0;
        for (int c = 0; c < PIPE_WIDTH; c++) begin
            w_cidx[c]   = r_head + TAG_WIDTH'(c);
            w_commit[c] = w_run && r_valid[w_cidx[c]] && r_done[w_cidx[c]];
            w_run       = w_commit[c];
            if (w_commit[c]) begin
                w_commit_n = w_commit_n + CNT_W'(1);
            end
            o_commit_we[c]   = w_commit[c] && r_has_rd[w_cidx[c]] && (r_rd[w_cidx[c]] != 5'd0);
            o_commit_addr[c] = r_rd[w_cidx[c]];
            o_commit_tag[c]  = w_cidx[c];
            o_commit_data[c] = r_data[w_cidx[c]];
            o_commit_pc[c]   = r_pc[w_cidx[c]];
        end
    end

    assign w_count_next = r_count + w_alloc_n - w_commit_n;
    assign o_rob_count  = r_count;
    assign o_rob_empty  = (r_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_done   <= '0;
            r_has_rd <= '0;
            for (int e = 0; e < ROB_DEPTH; e++) begin
                r_rd[e]   <= '0;
                r_pc[e]   <= '0;
                r_data[e] <= '0;
            end
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            r_head  <= r_head + w_commit_n[TAG_WIDTH-1:0];
            r_tail  <= r_tail + w_alloc_n[TAG_WIDTH-1:0];
            r_count <= w_count_next;
            for (int i = 0; i < PIPE_WIDTH; i++) begin
                if (i_rob_disp_we[i]) begin
                    r_rd[i_rob_disp_tag[i]]     <= i_rob_disp_rd[i];
                    r_has_rd[i_rob_disp_tag[i]] <= i_rob_disp_has_rd[i];
                    r_pc[i_rob_disp_tag[i]]     <= i_rob_disp_pc[i];
                end
            end
            // Ascending lane order lets the higher CDB lane win on a tag collision.
            for (int i = 0; i < PIPE_WIDTH; i++) begin
                if (i_cdb_valid[i] && r_valid[i_cdb_tag[i]]) begin
                    r_done[i_cdb_tag[i]] <= 1'b1;
                    r_data[i_cdb_tag[i]] <= i_cdb_data[i];
                end
            end
            for (int c = 0; c < PIPE_WIDTH; c++) begin
                if (w_commit[c]) begin
                    r_valid[w_cidx[c]] <= 1'b0;
                    r_done[w_cidx[c]]  <= 1'b0;
                end
            end
            for (int i = 0; i < PIPE_WIDTH; i++) begin
                if (w_alloc[i]) begin
                    r_valid[o_rob_alloc_tags[i]] <= 1'b1;
                    r_done[o_rob_alloc_tags[i]]  <= 1'b0;
                end
            end
        end
    end

endmodule
